reg_bist_engine: RTL and testbench

- Hardware self-test driver/checker for one enable-gated storage register (d/en/rst in, q out).
- Drives the register's reset, enable and data inputs with a fixed pattern sequence, then reads q back and compares it against the expected value.
- Checks synchronous reset, data load, and hold while enable is low; reports pass/fail with the first failing pattern index and the captured data.
- Sits between the BIST top-level controller and each register under test.

---
 rtl/reg_bist_engine.sv | 202 ++++++++++++++++++++
 tb/tb_reg_bist_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bist_engine.sv
// reg_bist_engine: self-test driver/checker for one enable-gated storage register.
// Drives rst/en/d of the register under test through a reset check, four fixed
// patterns and a walking-one sequence, checking load and hold behaviour of each.
// Optional feature: define REG_BIST_MISR_EN to add a MISR signature over every
// compared dut_q value (adds parameter MISR_POLY and output port signature).
module reg_bist_engine #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned IDX_W       = 8
`ifdef REG_BIST_MISR_EN
   ,
   parameter logic [DATA_WIDTH-1:0] MISR_POLY = DATA_WIDTH'(32'h0040_0007)
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  dut_rst,
   output logic                  dut_en,
   output logic [DATA_WIDTH-1:0] dut_d,
   input  logic [DATA_WIDTH-1:0] dut_q,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [IDX_W-1:0]      fail_idx,
   output logic [DATA_WIDTH-1:0] fail_data
`ifdef REG_BIST_MISR_EN
   ,
   output logic [DATA_WIDTH-1:0] signature
`endif
);

   localparam int unsigned N_PAT = DATA_WIDTH + 4;
   localparam int unsigned HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_PAT);
   localparam logic [HC_W-1:0]  LAST_HOLD = HC_W'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_RCHK,
      S_WRITE,
      S_CHECK,
      S_HOLD,
      S_DONE
   } state_t;

   state_t                state;
   logic [IDX_W-1:0]      idx;
   logic [HC_W-1:0]       hold_cnt;
   logic [DATA_WIDTH-1:0] pat;
   logic [IDX_W-1:0]      next_idx_c;
   logic [DATA_WIDTH-1:0] next_pat_c;
   logic [DATA_WIDTH-1:0] first_pat_c;
   logic                  accept_c;

   // Pattern for check index i (1..N); index 0 is the reset check and has no pattern.
   function automatic logic [DATA_WIDTH-1:0] pattern_of(input logic [IDX_W-1:0] i);
      logic [DATA_WIDTH-1:0] p;
      p = '0;
      case (i)
         IDX_W'(1): p = '1;
         IDX_W'(2): for (int b = 0; b < int'(DATA_WIDTH); b++) p[b] = ((b % 2) == 1);
         IDX_W'(3): for (int b = 0; b < int'(DATA_WIDTH); b++) p[b] = ((b % 2) == 0);
         IDX_W'(4): p = '0;
         default:   p = DATA_WIDTH'(1) << (i - IDX_W'(5));
      endcase
      return p;
   endfunction

   // Next pattern index/value and start acceptance.
   always_comb begin
      next_idx_c  = idx + IDX_W'(1);
      next_pat_c  = pattern_of(next_idx_c);
      first_pat_c = pattern_of(IDX_W'(1));
      accept_c    = start && ((state == S_IDLE) || (state == S_DONE));
   end

   // Test sequencer with registered register-under-test drive and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         hold_cnt  <= '0;
         pat       <= '0;
         dut_rst   <= 1'b0;
         dut_en    <= 1'b0;
         dut_d     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_idx  <= '0;
         fail_data <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept_c) begin
                  state     <= S_RST;
                  idx       <= '0;
                  hold_cnt  <= '0;
                  dut_rst   <= 1'b1;
                  dut_en    <= 1'b1;
                  dut_d     <= '1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  fail_idx  <= '0;
                  fail_data <= '0;
               end
            end
            S_RST: begin
               state   <= S_RCHK;
               dut_rst <= 1'b0;
               dut_en  <= 1'b0;
               dut_d   <= '1;
            end
            S_RCHK: begin
               if (dut_q != '0) begin
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  pass      <= 1'b0;
                  fail_idx  <= '0;
                  fail_data <= dut_q;
                  dut_en    <= 1'b0;
                  dut_d     <= '0;
               end else begin
                  state  <= S_WRITE;
                  idx    <= IDX_W'(1);
                  pat    <= first_pat_c;
                  dut_en <= 1'b1;
                  dut_d  <= first_pat_c;
               end
            end
            S_WRITE: begin
               state  <= S_CHECK;
               dut_en <= 1'b0;
               dut_d  <= ~pat;
            end
            S_CHECK, S_HOLD: begin
               if (dut_q != pat) begin
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  pass      <= 1'b0;
                  fail_idx  <= idx;
                  fail_data <= dut_q;
                  dut_d     <= '0;
               end else if (state == S_CHECK) begin
                  state    <= S_HOLD;
                  hold_cnt <= '0;
               end else if (hold_cnt != LAST_HOLD) begin
                  hold_cnt <= hold_cnt + HC_W'(1);
               end else if (idx == LAST_IDX) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= 1'b1;
                  dut_d <= '0;
               end else begin
                  state  <= S_WRITE;
                  idx    <= next_idx_c;
                  pat    <= next_pat_c;
                  dut_en <= 1'b1;
                  dut_d  <= next_pat_c;
               end
            end
            default: begin
               state   <= S_IDLE;
               dut_rst <= 1'b0;
               dut_en  <= 1'b0;
               dut_d   <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef REG_BIST_MISR_EN
   logic [DATA_WIDTH-1:0] sig_next_c;

   // MISR step over the current dut_q value.
   always_comb begin
      sig_next_c = {signature[DATA_WIDTH-2:0], 1'b0}
                 ^ (signature[DATA_WIDTH-1] ? MISR_POLY : '0)
                 ^ dut_q;
   end

   // Signature accumulates on compare cycles, clears on accepted start, freezes otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         signature <= '0;
      end else if (accept_c) begin
         signature <= '0;
      end else if ((state == S_RCHK) || (state == S_CHECK) || (state == S_HOLD)) begin
         signature <= sig_next_c;
      end
   end
`endif

endmodule

// File: tb/tb_reg_bist_engine.sv
// Bench for reg_bist_engine: faultable register model under test, a cycle-level
// reference of the test schedule, and a per-cycle output compare.
module tb_reg_bist_engine;

   localparam int DW = 32;
   localparam int H  = 2;
   localparam int N  = DW + 4;
   localparam int S  = 2 + N * (2 + H);
   localparam logic [31:0] POLY = 32'h0040_0007;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          dut_rst;
   logic          dut_en;
   logic [DW-1:0] dut_d;
   logic [DW-1:0] dut_q;
   logic          busy;
   logic          done;
   logic          pass;
   logic [7:0]    fail_idx;
   logic [DW-1:0] fail_data;
`ifdef REG_BIST_MISR_EN
   logic [DW-1:0] signature;
`endif

   reg_bist_engine #(.DATA_WIDTH(DW), .HOLD_CYCLES(H), .IDX_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dut_rst   (dut_rst),
      .dut_en    (dut_en),
      .dut_d     (dut_d),
      .dut_q     (dut_q),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_idx  (fail_idx),
      .fail_data (fail_data)
`ifdef REG_BIST_MISR_EN
      ,
      .signature (signature)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Faultable register under test: 0 good, 1 q[0] stuck-1, 2 q[3] stuck-0, 3 ignores en.
   int          mode = 0;
   int          flip_cyc = -1;
   logic [31:0] flip_mask = '0;
   logic [31:0] rq = '0;
   logic [31:0] or_m;
   logic [31:0] and_m;
   int          fcyc = 0;

   assign or_m  = (mode == 1) ? 32'h1 : 32'h0;
   assign and_m = (mode == 2) ? ~32'h8 : 32'hFFFF_FFFF;
   assign dut_q = ((rq | or_m) & and_m) ^ ((fcyc == flip_cyc) ? flip_mask : 32'h0);

   always @(posedge clk) begin
      if (dut_rst) rq <= '0;
      else if (dut_en || mode == 3) rq <= dut_d;
   end

   always @(posedge clk) begin
      if (start && !busy && !rst) fcyc <= 0;
      else fcyc <= fcyc + 1;
   end

   // Reference schedule and expected result of one run.
   logic        s_rst [0:S-1];
   logic        s_en  [0:S-1];
   logic [31:0] s_d   [0:S-1];
   logic        s_cmp [0:S-1];
   logic [31:0] s_exp [0:S-1];
   int          s_idx [0:S-1];
   int          m_len;
   logic        m_pass;
   logic [7:0]  m_idx;
   logic [31:0] m_data;
   logic [31:0] m_sig;

   function automatic logic [31:0] pat(input int p);
      case (p)
         1: return 32'hFFFF_FFFF;
         2: return 32'hAAAA_AAAA;
         3: return 32'h5555_5555;
         4: return 32'h0000_0000;
         default: return 32'h1 << (p - 5);
      endcase
   endfunction

   function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] v);
      return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ v;
   endfunction

   task automatic model_run(input int md, input int fc, input logic [31:0] fm);
      int k;
      logic [31:0] r;
      logic [31:0] obs;
      logic [31:0] om;
      logic [31:0] am;
      k = 0;
      s_rst[k] = 1; s_en[k] = 1; s_d[k] = '1; s_cmp[k] = 0; s_exp[k] = 0; s_idx[k] = 0; k++;
      s_rst[k] = 0; s_en[k] = 0; s_d[k] = '1; s_cmp[k] = 1; s_exp[k] = 0; s_idx[k] = 0; k++;
      for (int p = 1; p <= N; p++) begin
         s_rst[k] = 0; s_en[k] = 1; s_d[k] = pat(p); s_cmp[k] = 0; s_exp[k] = 0; s_idx[k] = p; k++;
         for (int j = 0; j <= H; j++) begin
            s_rst[k] = 0; s_en[k] = 0; s_d[k] = ~pat(p); s_cmp[k] = 1; s_exp[k] = pat(p);
            s_idx[k] = p; k++;
         end
      end
      om = (md == 1) ? 32'h1 : 32'h0;
      am = (md == 2) ? ~32'h8 : 32'hFFFF_FFFF;
      r = '0; m_sig = '0; m_len = S; m_pass = 1; m_idx = '0; m_data = '0;
      for (int c = 0; c < S; c++) begin
         obs = ((r | om) & am) ^ ((c == fc) ? fm : 32'h0);
         if (s_cmp[c]) begin
            m_sig = misr(m_sig, obs);
            if (obs != s_exp[c]) begin
               m_pass = 0; m_idx = 8'(s_idx[c]); m_data = obs; m_len = c + 1;
               break;
            end
         end
         if (s_rst[c]) r = '0;
         else if (s_en[c] || md == 3) r = s_d[c];
      end
   endtask

   // Per-cycle compare of every DUT output against the reference schedule.
   int   cyc = 0;
   logic active = 0;
   logic [76:0] got_v, exp_v;
   always @(negedge clk) begin
      if (active) begin
         got_v = {busy, done, pass, dut_rst, dut_en, fail_idx, dut_d, fail_data};
         if (cyc < m_len)
            exp_v = {1'b1, 1'b0, 1'b0, s_rst[cyc], s_en[cyc], 8'h0, s_d[cyc], 32'h0};
         else
            exp_v = {1'b0, 1'b1, m_pass, 1'b0, 1'b0, m_idx, 32'h0, m_data};
         vectors++;
         if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle_%0d outputs got=%h expected=%h", cyc, got_v, exp_v);
         end
`ifdef REG_BIST_MISR_EN
         if (cyc >= m_len) begin
            vectors++;
            if (signature !== m_sig) begin
               miscompares++;
               $display("FAIL cycle_%0d signature got=%h expected=%h", cyc, signature, m_sig);
            end
         end
`endif
         cyc++;
      end
   end

   int busy_cnt = 0;
   always @(negedge clk) if (busy) busy_cnt++;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h expected=%h", nm, got, exp);
      end
   endtask

   // Launch a run, optionally pulse start again at cycle ign (>0) while busy.
   task automatic run(input int md, input int fc, input logic [31:0] fm, input int ign);
      mode = md; flip_cyc = fc; flip_mask = fm;
      model_run(md, fc, fm);
      @(posedge clk); #1;
      start = 1; busy_cnt = 0;
      @(posedge clk); #1;
      start = 0; cyc = 0; active = 1;
      if (ign > 0) begin
         repeat (ign) @(posedge clk);
         #1 start = 1;
         @(posedge clk); #1 start = 0;
         repeat (m_len + 3 - ign - 1) @(posedge clk);
      end else begin
         repeat (m_len + 3) @(posedge clk);
      end
      #1 active = 0;
   endtask

`ifdef REG_BIST_MISR_EN
   logic [31:0] clean_sig;
`endif

   initial begin
      rst = 1; start = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {busy, done, pass, dut_rst, dut_en, fail_idx, dut_d, fail_data}, '0);
      @(posedge clk); #1 rst = 0;

      // Good register, with an ignored start pulse mid-run.
      run(0, -1, '0, 10);
      chk("good_busy_cycles", 64'(busy_cnt), 64'd146);
      chk("good_result", {done, pass, fail_idx, fail_data}, {1'b1, 1'b1, 8'h00, 32'h0});

      // Rerun from DONE gives identical results.
      run(0, -1, '0, 0);
      chk("rerun_busy_cycles", 64'(busy_cnt), 64'd146);
      chk("rerun_result", {done, pass, fail_idx, fail_data}, {1'b1, 1'b1, 8'h00, 32'h0});

      run(1, -1, '0, 0);
      chk("stuck1_bit0", {done, pass, fail_idx, fail_data}, {1'b1, 1'b0, 8'h00, 32'h0000_0001});
      run(2, -1, '0, 0);
      chk("stuck0_bit3", {done, pass, fail_idx, fail_data}, {1'b1, 1'b0, 8'h01, 32'hFFFF_FFF7});
      run(3, -1, '0, 0);
      chk("ignore_en", {done, pass, fail_idx, fail_data}, {1'b1, 1'b0, 8'h01, 32'h0000_0000});

      // Reset mid-run, with start asserted alongside: reset wins.
      mode = 0; model_run(0, -1, '0);
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0; cyc = 0; active = 1;
      repeat (40) @(posedge clk);
      #1 active = 0; rst = 1; start = 1;
      @(posedge clk); #1 rst = 0; start = 0;
      @(negedge clk);
      chk("midrun_reset", {busy, done, pass, dut_rst, dut_en, fail_idx, dut_d, fail_data}, '0);
      @(negedge clk);
      chk("after_reset_idle", {busy, done, dut_rst, dut_en}, '0);

      run(0, -1, '0, 0);
      chk("post_reset_run", {done, pass, fail_idx, fail_data}, {1'b1, 1'b1, 8'h00, 32'h0});

`ifdef REG_BIST_MISR_EN
      run(0, -1, '0, 0);
      clean_sig = m_sig;
      chk("misr_clean", 64'(signature), 64'(clean_sig));
      run(0, 20, 32'h0000_0100, 0);
      chk("misr_flipped", 64'(signature), 64'(m_sig));
      vectors++;
      if (signature === clean_sig) begin
         miscompares++;
         $display("FAIL misr_changes got=%h expected_not=%h", signature, clean_sig);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
